// File: rtl/grant_responder.sv
// Two-source grant responder: grants io_b/io_c one at a time for a bounded hold window.
// Define GRANT_RESPONDER_FIXED_PRIO_EN to tie simultaneous-request priority to B.
module grant_responder #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_b,
    input  logic             io_c,
    output logic             io_gnt_b,
    output logic             io_gnt_c,
    output logic             io_busy,
    output logic             io_done,
    output logic [CNT_W-1:0] io_gnt_count
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic               prio_c_q, prio_c_d;
    logic               gnt_b_d, gnt_c_d, busy_d, done_d;
    logic [CNT_W-1:0]   count_d;
    logic               pick_c;
    logic               release_now;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            prio_c_q     <= 1'b0;
            io_gnt_b     <= 1'b0;
            io_gnt_c     <= 1'b0;
            io_busy      <= 1'b0;
            io_done      <= 1'b0;
            io_gnt_count <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            prio_c_q     <= prio_c_d;
            io_gnt_b     <= gnt_b_d;
            io_gnt_c     <= gnt_c_d;
            io_busy      <= busy_d;
            io_done      <= done_d;
            io_gnt_count <= count_d;
        end
    end

    // Outputs are computed for the next state so that every output stays registered.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        prio_c_d    = prio_c_q;
        gnt_b_d     = io_gnt_b;
        gnt_c_d     = io_gnt_c;
        busy_d      = io_busy;
        done_d      = 1'b0;
        count_d     = io_gnt_count;
        pick_c      = 1'b0;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (io_b || io_c) begin
                    pick_c  = io_c && (!io_b || prio_c_q);
                    state_d = GRANT;
                    hold_d  = HOLD_LOAD;
                    gnt_b_d = !pick_c;
                    gnt_c_d = pick_c;
                    busy_d  = 1'b1;
                    if (io_gnt_count != '1) begin
                        count_d = io_gnt_count + 1'b1;
                    end
                end else begin
                    gnt_b_d = 1'b0;
                    gnt_c_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end

            GRANT: begin
                release_now = (io_gnt_b && !io_b) || (io_gnt_c && !io_c) || (hold_q == '0);
                if (release_now) begin
                    state_d = RELEASE;
                    gnt_b_d = 1'b0;
                    gnt_c_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b1;
                    // Pointer is updated on RELEASE entry, while the grant owner is still visible.
`ifdef GRANT_RESPONDER_FIXED_PRIO_EN
                    prio_c_d = 1'b0;
`else
                    prio_c_d = io_gnt_b;
`endif
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            RELEASE: begin
                state_d = IDLE;
                gnt_b_d = 1'b0;
                gnt_c_d = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                gnt_b_d = 1'b0;
                gnt_c_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_grant_responder.sv
// Self-checking bench for grant_responder: table-driven vectors through a scoreboard queue,
// plus hand-written async-reset and counter-saturation sequences.
module tb_grant_responder;

    typedef struct {
        bit          b;
        bit          c;
        bit          gb;
        bit          gc;
        bit          busy;
        bit          done;
        int unsigned cnt;
    } vec_t;

`ifdef GRANT_RESPONDER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       io_b = 1'b0, io_c = 1'b0;
    logic       io_gnt_b, io_gnt_c, io_busy, io_done;
    logic [7:0] io_gnt_count;

    logic       s_b = 1'b0, s_c = 1'b0;
    logic       s_gnt_b, s_gnt_c, s_busy, s_done;
    logic [1:0] s_gnt_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    grant_responder #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .io_b(io_b), .io_c(io_c),
        .io_gnt_b(io_gnt_b), .io_gnt_c(io_gnt_c), .io_busy(io_busy),
        .io_done(io_done), .io_gnt_count(io_gnt_count)
    );

    grant_responder #(.HOLD_CYCLES(1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .io_b(s_b), .io_c(s_c),
        .io_gnt_b(s_gnt_b), .io_gnt_c(s_gnt_c), .io_busy(s_busy),
        .io_done(s_done), .io_gnt_count(s_gnt_count)
    );

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endfunction

    // who: 0 none, 1 B, 2 C, 3 C under round-robin but B when priority is fixed
    function automatic void add(bit b, bit c, int who, bit busy, bit done, int unsigned cnt);
        vec_t v;
        int   w;
        w      = (who == 3) ? (FIXED ? 1 : 2) : who;
        v.b    = b;
        v.c    = c;
        v.gb   = (w == 1);
        v.gc   = (w == 2);
        v.busy = busy;
        v.done = done;
        v.cnt  = cnt;
        tbl.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        io_b = v.b;
        io_c = v.c;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, " gnt_b"}, 32'(io_gnt_b), 32'(e.gb));
            chk({tag, " gnt_c"}, 32'(io_gnt_c), 32'(e.gc));
            chk({tag, " busy"},  32'(io_busy),  32'(e.busy));
            chk({tag, " done"},  32'(io_done),  32'(e.done));
            chk({tag, " count"}, 32'(io_gnt_count), e.cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        // Simultaneous requests: B, C, B, C (all B with fixed priority)
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned k = 0; k < 4; k++) add(1, 1, (r % 2 == 0) ? 1 : 3, 1, 0, r + 1);
            add(1, 1, 0, 1, 1, r + 1);
            add((r == 3) ? 1'b0 : 1'b1, (r == 3) ? 1'b0 : 1'b1, 0, 0, 0, r + 1);
        end
        // Early release of C after two grant cycles
        add(0, 1, 2, 1, 0, 5);
        add(0, 1, 2, 1, 0, 5);
        add(0, 0, 0, 1, 1, 5);
        add(0, 0, 0, 0, 0, 5);
        // C request during B grant is ignored; RELEASE always returns through IDLE
        add(1, 0, 1, 1, 0, 6);
        add(1, 1, 1, 1, 0, 6);
        add(0, 1, 0, 1, 1, 6);
        add(0, 1, 0, 0, 0, 6);
        add(0, 1, 2, 1, 0, 7);
        add(0, 0, 0, 1, 1, 7);
        add(0, 0, 0, 0, 0, 7);
        // Release on the very first grant cycle
        add(1, 0, 1, 1, 0, 8);
        add(0, 0, 0, 1, 1, 8);
        add(0, 0, 0, 0, 0, 8);
        // Both high with pointer at C (round-robin) to set up the reset test
        add(1, 1, 3, 1, 0, 9);
        add(1, 1, 3, 1, 0, 9);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset gnt_b", 32'(io_gnt_b), 0);
        chk("reset gnt_c", 32'(io_gnt_c), 0);
        chk("reset busy",  32'(io_busy), 0);
        chk("reset done",  32'(io_done), 0);
        chk("reset count", 32'(io_gnt_count), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle busy", 32'(io_busy), 0);

        for (int unsigned i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a grant
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async gnt_b", 32'(io_gnt_b), 0);
        chk("async gnt_c", 32'(io_gnt_c), 0);
        chk("async busy",  32'(io_busy), 0);
        chk("async done",  32'(io_done), 0);
        chk("async count", 32'(io_gnt_count), 0);
        chk("async sat_count", 32'(s_gnt_count), 0);
        @(posedge clk);
        #1;
        chk("inreset done", 32'(io_done), 0);
        chk("inreset gnt_c", 32'(io_gnt_c), 0);
        @(negedge clk);
        reset = 1'b1;
        v = '{b: 1, c: 1, gb: 1, gc: 0, busy: 1, done: 0, cnt: 1};
        apply(v, "post_reset_grant");
        v = '{b: 0, c: 0, gb: 0, gc: 0, busy: 1, done: 1, cnt: 1};
        apply(v, "post_reset_release");
        v = '{b: 0, c: 0, gb: 0, gc: 0, busy: 0, done: 0, cnt: 1};
        apply(v, "post_reset_idle");

        // Saturation with CNT_W=2, HOLD_CYCLES=1: one-cycle grants, count 1,2,3,3,3
        s_b = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d gnt_b", k), 32'(s_gnt_b), 1);
            chk($sformatf("sat%0d count", k), 32'(s_gnt_count), (k < 2) ? k + 1 : 3);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d rel_gnt", k), 32'(s_gnt_b), 0);
            chk($sformatf("sat%0d rel_done", k), 32'(s_done), 1);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d idle_busy", k), 32'(s_busy), 0);
            chk($sformatf("sat%0d idle_gnt_c", k), 32'(s_gnt_c), 0);
        end
        s_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/grant_responder.md
# grant_responder

Responder side of the two-source request pair (`io_b` / `io_c`) that the activity detector ORs into a single registered flag. The block answers those requests: it grants exactly one source at a time for a bounded hold window, pulses a completion strobe, and alternates priority between sources. It sits beside the detector and drives the acknowledge path back to both requesters.

## Interface
- `HOLD_CYCLES`, default 4: maximum grant length in cycles, legal range 1..255.
- `CNT_W`, default 8: width of the grant counter.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset (asserted at 0).
- `io_b` input, 1 bit: request from source B, level, held until granted.
- `io_c` input, 1 bit: request from source C, level, held until granted.
- `io_gnt_b` output, 1 bit: grant to B, registered.
- `io_gnt_c` output, 1 bit: grant to C, registered.
- `io_busy` output, 1 bit: high in GRANT or RELEASE.
- `io_done` output, 1 bit: one-cycle pulse in RELEASE.
- `io_gnt_count` output, CNT_W bits: number of grants issued, saturating.

## Operation
- FSM states: IDLE, GRANT, RELEASE. All outputs are registered.
- On reset, regardless of clock: state=IDLE, `io_gnt_b`=0, `io_gnt_c`=0, `io_busy`=0, `io_done`=0, `io_gnt_count`=0, priority pointer=B, hold counter=0.
- IDLE, transitions on a clock edge:
  - Neither request high: stay in IDLE.
  - Exactly one request high: grant that source and go to GRANT.
  - Both requests high: grant the source named by the priority pointer and go to GRANT.
  - Every GRANT entry loads the hold counter with HOLD_CYCLES-1 and increments `io_gnt_count`. The counter saturates at 2^CNT_W-1 and never wraps.
- GRANT:
  - Holds exactly one grant high.
  - If the granted source's request is low at an edge, go to RELEASE (early release).
  - Otherwise, if the hold counter is 0, go to RELEASE (timeout).
  - Otherwise, decrement the hold counter.
- RELEASE, one cycle:
  - Both grants low, `io_done`=1.
  - The priority pointer moves to the source that was not just granted.
  - Next state is IDLE unconditionally, so there is no back-to-back grant without an IDLE cycle.
- A request from the non-granted source during GRANT has no effect until IDLE.

## Timing
- Request seen high at edge t in IDLE: the grant is high in cycle t+1 (1-cycle latency).
- With the request held, the grant stays high for exactly HOLD_CYCLES cycles. `io_done` is high in the next cycle, and IDLE follows one cycle later.
- Minimum request-to-request turnaround for the same source: HOLD_CYCLES+2 cycles.
- Early release: if the granted request is low at edge k, the grant is low and `io_done` is high in cycle k+1.
- HOLD_CYCLES=1: the grant lasts one cycle; no decrement occurs.
- `io_busy` is high exactly in the cycles where state is GRANT or RELEASE.
- Reset asserted mid-GRANT clears the grant asynchronously, with no `io_done` pulse. After reset release, priority is B.

## Configuration
- `GRANT_RESPONDER_FIXED_PRIO_EN`:
  - Defined: the priority pointer is tied to B. Simultaneous requests always grant B, and RELEASE does not toggle the pointer.
  - Undefined (default): round-robin behaviour exactly as described above.

## Test plan
- Single request, HOLD_CYCLES=4: raise `io_b` at cycle 0 and hold it. Required: `io_gnt_b` high for cycles 1–4, `io_done` high at cycle 5, `io_gnt_count`=1.
- Simultaneous requests: `io_b`=`io_c`=1 held. Required grant order B, C, B, C. Each grant lasts 4 cycles and each is separated by one RELEASE cycle plus one IDLE cycle.
- Early release: grant C, then drop `io_c` after 2 grant cycles. Required: `io_gnt_c` high for 2 cycles, then `io_done` high in the next cycle.
- Async reset mid-GRANT: assert `reset`=0 between clock edges. Required: all outputs 0 immediately, count=0. After release with both requests high, B is granted first.
- Counter saturation, CNT_W=2: issue 5 grants. Required: `io_gnt_count` reads 1, 2, 3, 3, 3.
- Build with `GRANT_RESPONDER_FIXED_PRIO_EN` defined, both requests held. Required: only `io_gnt_b` is ever granted, and `io_gnt_c` stays 0.
